// File: rtl/keccak_round_ctrl_if.sv
// rtl/keccak_round_ctrl_if.sv - handshake and round-datapath bundle for keccak_round_ctrl
//
// Groups the upstream (in_*), downstream (out_*) and round datapath (rnd_*)
// signals of the Keccak-f[1600] round sequencer.
//   slave  : the sequencer side (keccak_round_ctrl)
//   master : the surrounding sponge logic / round datapath side
// Signals:
//   in_valid, in_state   upstream offer of a state to permute
//   in_ready             sequencer accepts a new state
//   rnd_state_o          state register, feeds the round datapath
//   rnd_idx_o            round index, feeds the round datapath (iota RC select)
//   rnd_state_i          round datapath result
//   out_valid, out_state permuted state offered downstream
//   out_ready            downstream takes out_state
//   busy                 permutation running or waiting for handoff
interface keccak_round_ctrl_if #(
  parameter int STATE_W = 1600,
  parameter int RND_W   = 5
) ();
  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] in_state;
  logic [STATE_W-1:0] rnd_state_o;
  logic [RND_W-1:0]   rnd_idx_o;
  logic [STATE_W-1:0] rnd_state_i;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] out_state;
  logic               busy;

  modport slave (
    input  in_valid, in_state, rnd_state_i, out_ready,
    output in_ready, rnd_state_o, rnd_idx_o, out_valid, out_state, busy
  );

  modport master (
    output in_valid, in_state, rnd_state_i, out_ready,
    input  in_ready, rnd_state_o, rnd_idx_o, out_valid, out_state, busy
  );
endinterface

// File: rtl/keccak_round_ctrl.sv
// rtl/keccak_round_ctrl.sv - Keccak-f[1600] round sequencer holding the permutation state
//
// Accepts a state from upstream, iterates it through the external combinational
// round datapath for NUM_ROUNDS clocks (one round per clock), then offers the
// result downstream with a valid/ready handshake.
// Ports:
//   clk      clock, all state on rising edge
//   rst_n    asynchronous active-low reset
//   bus      keccak_round_ctrl_if.slave (in_*, out_*, rnd_*, busy)
//   abort_i  only when KECCAK_CTRL_ABORT_EN is defined: drops the running job
// Optional feature macro: KECCAK_CTRL_ABORT_EN
module keccak_round_ctrl #(
  parameter int STATE_W    = 1600,
  parameter int NUM_ROUNDS = 24,
  parameter int RND_W      = 5
) (
  input logic                clk,
  input logic                rst_n,
  keccak_round_ctrl_if.slave bus
`ifdef KECCAK_CTRL_ABORT_EN
  ,
  input logic                abort_i
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS - 1);

  logic [1:0]         fsm;
  logic [RND_W-1:0]   rnd;
  logic [STATE_W-1:0] st;
  logic               abort_hit;

`ifdef KECCAK_CTRL_ABORT_EN
  // Abort only matters once a job is in flight; in IDLE it is a no-op.
  assign abort_hit = abort_i && (fsm != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm <= S_IDLE;
      rnd <= '0;
      st  <= '0;
    end else if (abort_hit) begin
      // Abort outranks both the round update and the DONE handoff.
      fsm <= S_IDLE;
      rnd <= '0;
      st  <= '0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (bus.in_valid) begin
            st  <= bus.in_state;
            rnd <= '0;
            fsm <= S_RUN;
          end
        end
        S_RUN: begin
          st <= bus.rnd_state_i;
          if (rnd == LAST_RND) begin
            rnd <= '0;
            fsm <= S_DONE;
          end else begin
            rnd <= rnd + RND_W'(1);
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            fsm <= S_IDLE;
          end
        end
        default: begin
          fsm <= S_IDLE;
          rnd <= '0;
        end
      endcase
    end
  end

  // All handshake outputs decode the registered FSM state only, so there is
  // no combinational path from in_valid/out_ready to the ready/valid outputs.
  assign bus.in_ready    = (fsm == S_IDLE);
  assign bus.busy        = (fsm == S_RUN) || (fsm == S_DONE);
  assign bus.out_valid   = (fsm == S_DONE);
  assign bus.rnd_idx_o   = (fsm == S_RUN) ? rnd : '0;
  assign bus.rnd_state_o = st;
  assign bus.out_state   = st;

endmodule
